// File: rtl/de1_soc_niosii_project_pio_input_key.sv
//----------------------------------------------------------------------------
// de1_soc_niosii_project_pio_input_key
//
// Avalon-MM slave parallel input port for the DE1-SoC push-buttons. It is the
// read-side companion of the LED output PIO on the Nios II system bus.
//
// The pad inputs are synchronised and exposed live. Selected edges are latched
// into a sticky capture register. A per-bit mask combines the captured bits
// into one level-sensitive interrupt request.
//
// Register map (2-bit word address, zero wait states, read latency 0):
//   0 DATA          synchronised in_port value (read-only)
//   1 DIRECTION     always reads 0 (input-only port)
//   2 IRQ_MASK      R/W, WIDTH bits
//   3 EDGE_CAPTURE  sticky edge bits; writing 1 to a bit clears it
//
// The port does no debouncing, so bounce shows up as multiple edges. Pulses
// shorter than one clk period may be missed.
//
// Parameters:
//   WIDTH        number of input bits (1..32)
//   EDGE_TYPE    0 = rising, 1 = falling, 2 = any edge
//   SYNC_STAGES  synchroniser depth (2..4)
//
// Ports:
//   clk         system clock; all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   address     register select
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data (bits above WIDTH-1 are ignored)
//   in_port     asynchronous pad inputs
//   readdata    read data, combinational from address and register state
//   irq         level interrupt request, active-high
//----------------------------------------------------------------------------
module de1_soc_niosii_project_pio_input_key #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Register addresses.
    localparam logic [1:0] ADDR_DATA         = 2'd0;
    localparam logic [1:0] ADDR_DIRECTION    = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

    // Edge selection encodings.
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;

    // The arm counter counts SYNC_STAGES+1 edges after reset and then holds.
    // By that point the chain and prev hold real pad values, so any edge the
    // detector reports is a genuine transition.
    localparam int              ARM_COUNT = SYNC_STAGES + 1;
    localparam int              ARM_W     = $clog2(ARM_COUNT + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_COUNT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  prev_q, prev_d;
    logic [WIDTH-1:0]                  mask_q, mask_d;
    logic [WIDTH-1:0]                  capture_q, capture_d;
    logic [ARM_W-1:0]                  arm_cnt_q, arm_cnt_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_raw;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] capture_clear;
    logic             armed;
    logic             wr_en;

    // The bits of writedata above WIDTH-1 have no destination. They are
    // reduced here so that every input bit has a visible sink.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign armed = (arm_cnt_q == ARM_DONE);
    assign wr_en = chipselect & ~write_n;

    // Synchroniser shift and prev tracking.
    always_comb begin
        // NOTE: every always_comb output gets a default assignment first, so
        // no path through the block can leave it unassigned and infer a latch.
        sync_d    = sync_q;
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync;
    end

    // Edge detection. This logic is fixed at elaboration by EDGE_TYPE.
    always_comb begin
        edge_raw = '0;
        if (EDGE_TYPE == EDGE_RISING) begin
            edge_raw = sync & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            edge_raw = ~sync & prev_q;
        end else begin
            edge_raw = sync ^ prev_q;
        end
        // Until the chain has filled, edges are artefacts of the zero reset.
        edge_det = armed ? edge_raw : '0;
    end

    // Arm counter.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (!armed) begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
    end

    // Register writes.
    always_comb begin
        mask_d        = mask_q;
        capture_clear = '0;
        if (wr_en && (address == ADDR_IRQ_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGE_CAPTURE)) begin
            capture_clear = writedata[WIDTH-1:0];
        end
        // The set term is ORed in after the clear. An edge that arrives
        // together with a clear of the same bit is therefore kept.
        capture_d = (capture_q & ~capture_clear) | edge_det;
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // The synchroniser is reset as well. DATA then reads a
            // deterministic 0 during reset, and the arm counter covers the
            // false edges this causes once reset is released.
            sync_q    <= '0;
            prev_q    <= '0;
            mask_q    <= '0;
            capture_q <= '0;
            arm_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All flops
            // then sample pre-edge values, which the synchroniser shift
            // depends on.
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            mask_q    <= mask_d;
            capture_q <= capture_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // readdata does not depend on chipselect. The interconnect only samples
    // it when the slave is selected.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:         readdata[WIDTH-1:0] = sync;
            ADDR_DIRECTION:    readdata            = '0;
            ADDR_IRQ_MASK:     readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAPTURE: readdata[WIDTH-1:0] = capture_q;
            default:           readdata            = '0;
        endcase
    end

    assign irq = |(capture_q & mask_q);

endmodule

// File: tb/tb_de1_soc_niosii_project_pio_input_key.sv
//----------------------------------------------------------------------------
// Testbench for de1_soc_niosii_project_pio_input_key.
//
// The main instance uses the default configuration (4 bits, falling edge,
// 2 sync stages). A second instance shares its inputs and captures any edge,
// which makes the post-reset false edges visible.
//----------------------------------------------------------------------------
module tb_de1_soc_niosii_project_pio_input_key;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [WIDTH-1:0] in_port;
    logic [31:0]      readdata;
    logic             irq;
    logic [31:0]      readdata_any;
    logic             irq_any;

    always #5 clk = ~clk;

    de1_soc_niosii_project_pio_input_key #(
        .WIDTH(WIDTH), .EDGE_TYPE(1), .SYNC_STAGES(2)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(readdata), .irq(irq)
    );

    de1_soc_niosii_project_pio_input_key #(
        .WIDTH(WIDTH), .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) u_dut_any (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(readdata_any), .irq(irq_any)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard of expected read results.
    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
        bit          any_edge;
    } sb_t;
    sb_t sb_q[$];

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.any_edge) begin
                check({e.name, " rd(any)"}, readdata_any, e.rd);
                check({e.name, " irq(any)"}, 32'(irq_any), 32'(e.irq));
            end else begin
                check({e.name, " rd"}, readdata, e.rd);
                check({e.name, " irq"}, 32'(irq), 32'(e.irq));
            end
        end
    endtask

    task automatic probe(input string name, input logic [1:0] a, input logic [31:0] rd,
                         input logic irq_exp, input bit any_edge = 1'b0);
        sb_t e;
        e.name = name; e.rd = rd; e.irq = irq_exp; e.any_edge = any_edge;
        address = a;
        sb_q.push_back(e);
        #1;
        drain();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    // Table of single-cycle register map vectors.
    typedef struct {
        string       name;
        logic        cs;
        logic        wn;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] rd;
        logic        irq;
    } vec_t;
    vec_t vecs[$];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{"data_write_ignored",  1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_000F, 1'b0});
        vecs.push_back('{"dir_write_ignored",   1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000, 1'b0});
        vecs.push_back('{"mask_upper_bits",     1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_000F, 1'b0});
        vecs.push_back('{"mask_write_5",        1'b1, 1'b0, 2'd2, 32'h0000_0005, 2'd2, 32'h0000_0005, 1'b0});
        vecs.push_back('{"cs_low_no_write",     1'b0, 1'b0, 2'd2, 32'h0000_000A, 2'd2, 32'h0000_0005, 1'b0});
        vecs.push_back('{"wn_high_no_write",    1'b1, 1'b1, 2'd2, 32'h0000_000A, 2'd2, 32'h0000_0005, 1'b0});
        vecs.push_back('{"cap_clear_idle",      1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000, 1'b0});
        vecs.push_back('{"data_after_writes",   1'b0, 1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_000F, 1'b0});

        reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0;

        // Every register reads 0 while reset is held.
        tick(2);
        for (int a = 0; a < 4; a++) probe("in_reset", 2'(a), 32'h0, 1'b0);

        // Release reset with the keys idle-high.
        #2 reset_n = 1'b1;
        tick(2);
        probe("data_after_release", 2'd0, 32'hF, 1'b0);
        probe("data_after_release", 2'd0, 32'hF, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            probe("no_false_capture", 2'd3, 32'h0, 1'b0);
            probe("no_false_capture", 2'd3, 32'h0, 1'b0, 1'b1);
        end

        // KEY0 press: check the latency of DATA and of the capture bit.
        bus_write(2'd2, 32'h1);
        in_port = 4'hE;
        tick(1);
        probe("key0_data_k", 2'd0, 32'hF, 1'b0);
        tick(1);
        probe("key0_data_k1", 2'd0, 32'hE, 1'b0);
        probe("key0_cap_k1", 2'd3, 32'h0, 1'b0);
        tick(1);
        probe("key0_cap_k2", 2'd3, 32'h1, 1'b1);
        probe("key0_cap_k2", 2'd3, 32'h1, 1'b1, 1'b1);

        bus_write(2'd3, 32'h1);
        probe("clear_bit0", 2'd3, 32'h0, 1'b0);

        // A release is a rising edge, which is not captured.
        in_port = 4'hF;
        tick(3);
        probe("release_no_cap", 2'd3, 32'h0, 1'b0);
        probe("release_data", 2'd0, 32'hF, 1'b0);

        // Zero-bit writes leave capture alone; one bits clear selectively.
        in_port = 4'hC;
        tick(3);
        probe("cap_0x3", 2'd3, 32'h3, 1'b1);
        bus_write(2'd3, 32'h0);
        probe("clear_zero_keeps", 2'd3, 32'h3, 1'b1);
        bus_write(2'd3, 32'h2);
        probe("clear_bit1_only", 2'd3, 32'h1, 1'b1);
        bus_write(2'd3, 32'hF);
        probe("clear_all", 2'd3, 32'h0, 1'b0);
        in_port = 4'hF;
        tick(3);

        // KEY2 is captured while masked off; enabling the mask raises irq.
        in_port = 4'hB;
        tick(3);
        probe("key2_masked", 2'd3, 32'h4, 1'b0);
        bus_write(2'd2, 32'h4);
        probe("mask_0x4_readback", 2'd2, 32'h4, 1'b1);
        bus_write(2'd2, 32'h1);
        probe("mask_off_irq_drop", 2'd2, 32'h1, 1'b0);
        bus_write(2'd3, 32'hF);
        in_port = 4'hF;
        tick(3);

        // An edge and a clear of the same bit arrive on the same clock edge.
        bus_write(2'd2, 32'h2);
        in_port = 4'hD;
        tick(3);
        probe("key1_cap", 2'd3, 32'h2, 1'b1);
        in_port = 4'hF;
        tick(3);
        probe("key1_release", 2'd3, 32'h2, 1'b1);
        in_port = 4'hD;
        tick(2);
        bus_write(2'd3, 32'h2);
        probe("set_wins_over_clear", 2'd3, 32'h2, 1'b1);
        bus_write(2'd3, 32'h2);
        probe("clear_after_collision", 2'd3, 32'h0, 1'b0);
        in_port = 4'hF;
        tick(3);

        // Register map vectors.
        foreach (vecs[i]) begin
            chipselect = vecs[i].cs; write_n = vecs[i].wn;
            address = vecs[i].waddr; writedata = vecs[i].wdata;
            @(posedge clk);
            #1;
            chipselect = 1'b0; write_n = 1'b1; writedata = '0;
            probe(vecs[i].name, vecs[i].raddr, vecs[i].rd, vecs[i].irq);
        end

        // Reset asserted in the middle of a cycle with everything set.
        bus_write(2'd2, 32'hF);
        in_port = 4'h0;
        tick(3);
        probe("all_captured", 2'd3, 32'hF, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        for (int a = 0; a < 4; a++) probe("mid_reset", 2'(a), 32'h0, 1'b0);

        // After reset, a held input produces no capture.
        tick(2);
        reset_n = 1'b1;
        tick(20);
        probe("held_no_cap", 2'd3, 32'h0, 1'b0);
        probe("held_no_cap", 2'd3, 32'h0, 1'b0, 1'b1);
        probe("held_data", 2'd0, 32'h0, 1'b0);

        // A genuine transition after arming is captured again.
        bus_write(2'd2, 32'hF);
        in_port = 4'hF;
        tick(3);
        probe("rise_after_reset", 2'd3, 32'h0, 1'b0);
        in_port = 4'h0;
        tick(3);
        probe("fall_after_reset", 2'd3, 32'hF, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
